// File: rtl/panel_pkg.sv
// -----------------------------------------------------------------------------
// panel_pkg
// Shared constants and types for the 7-column LED dot-matrix scan logic.
//   SEL_BLANK  : mux select code that picks no input (all rows dark)
//   NUM_COLS   : number of panel columns
//   LAST_COL   : highest column index
//   scan_state_t : column-scan sequencer states
//   next_col() : column index after c, wrapping back to 0 after the last column
// -----------------------------------------------------------------------------
package panel_pkg;

  localparam logic [2:0] SEL_BLANK = 3'd7;
  localparam int         NUM_COLS  = 7;
  localparam logic [2:0] LAST_COL  = 3'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  function automatic logic [2:0] next_col(input logic [2:0] c);
    return (c == LAST_COL) ? 3'd0 : c + 3'd1;
  endfunction

endpackage

// File: rtl/panel_dwell_timer.sv
// -----------------------------------------------------------------------------
// panel_dwell_timer
// Loadable down-counter that times column dwell and blanking intervals.
// Loading N keeps the current phase alive for N+1 cycles; done is high on the
// final cycle of the interval.
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   clr         in   force the count to zero
//   load        in   load load_val on this edge (overrides counting)
//   load_val    in   W-bit reload value (interval length minus one)
//   done        out  count is zero: this is the last cycle of the interval
//   expire_next out  count will be zero after this edge (lookahead of done)
// -----------------------------------------------------------------------------
module panel_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic         expire_next
);

  logic [W-1:0] count;

  // NOTE: synchronous reset -- rst_n is only looked at inside the clocked
  // block, so it never appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done        = (count == '0);
  // Lets the owner register flags that must line up with the final cycle.
  assign expire_next = load ? (load_val == '0) : (count <= W'(1));

endmodule

// File: rtl/panel_scan_ctrl.sv
// -----------------------------------------------------------------------------
// panel_scan_ctrl
// Column-scan sequencer for the 7-column LED dot-matrix panel. Steps the
// per-row 7:1 column mux select through codes 0..6, holding each for
// DWELL_CYCLES and inserting BLANK_CYCLES of code 7 between columns to
// suppress ghosting. Pulses frame_done once per frame and advances the
// message scroll offset every FRAMES_PER_STEP frames.
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   scan enable; dropping it returns to idle immediately
//   scroll_en  in   allow scroll_pos to advance (freezes frame counter when 0)
//   sel        out  mux select code {sel1, sel2, sel3}; 7 = blank
//   col_idx    out  column being shown (held during the blank that follows)
//   blank      out  high while sel = 7
//   frame_done out  one-cycle pulse on the last cycle of each frame
//   scroll_pos out  scroll offset, 0..MSG_LEN-1
// -----------------------------------------------------------------------------
module panel_scan_ctrl
  import panel_pkg::*;
#(
  parameter  int DWELL_CYCLES    = 1000,
  parameter  int BLANK_CYCLES    = 10,
  parameter  int FRAMES_PER_STEP = 30,
  parameter  int MSG_LEN         = 32,
  localparam int SP_W            = $clog2(MSG_LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            scroll_en,
  output logic [2:0]      sel,
  output logic [2:0]      col_idx,
  output logic            blank,
  output logic            frame_done,
  output logic [SP_W-1:0] scroll_pos
);

  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;

  scan_state_t     state, nxt_state;
  logic [2:0]      nxt_col;
  logic            t_clr, t_load, t_done, t_expire_next;
  logic [TW-1:0]   t_load_val;
  logic            fd_next;
  logic [FC_W-1:0] frame_cnt;

  panel_dwell_timer #(.W(TW)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (t_clr),
    .load        (t_load),
    .load_val    (t_load_val),
    .done        (t_done),
    .expire_next (t_expire_next)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nxt_state  = state;
    nxt_col    = col_idx;
    t_clr      = 1'b0;
    t_load     = 1'b0;
    t_load_val = DWELL_LOAD;

    if (!en) begin
      nxt_state = IDLE;
      nxt_col   = 3'd0;
      t_clr     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          nxt_state = SHOW;
          nxt_col   = 3'd0;
          t_load    = 1'b1;
        end
        SHOW: begin
          if (t_done) begin
            t_load = 1'b1;
            if (BLANK_CYCLES > 0) begin
              nxt_state  = BLANK;
              t_load_val = BLANK_LOAD;
            end else begin
              nxt_col = next_col(col_idx);
            end
          end
        end
        BLANK: begin
          if (t_done) begin
            nxt_state = SHOW;
            nxt_col   = next_col(col_idx);
            t_load    = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // The frame ends on the last cycle of column 6's blank, or of its dwell
  // when blanking is disabled; look one edge ahead so the pulse is registered.
  assign fd_next = !t_clr && t_expire_next && (nxt_col == LAST_COL) &&
                   ((BLANK_CYCLES > 0) ? (nxt_state == BLANK) : (nxt_state == SHOW));

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      col_idx    <= 3'd0;
      sel        <= SEL_BLANK;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      scroll_pos <= '0;
    end else begin
      state      <= nxt_state;
      col_idx    <= nxt_col;
      sel        <= (nxt_state == SHOW) ? nxt_col : SEL_BLANK;
      blank      <= (nxt_state != SHOW);
      frame_done <= fd_next;
      if (fd_next && scroll_en) begin
        if (frame_cnt == FC_W'(FRAMES_PER_STEP - 1)) begin
          frame_cnt  <= '0;
          scroll_pos <= (scroll_pos == SP_W'(MSG_LEN - 1)) ? '0 : scroll_pos + 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/panel_scan_ctrl.md
Name: panel_scan_ctrl

Overview:
- Column-scan sequencer for the 7-column LED dot-matrix panel.
- Generates the 3-bit select code for the per-row 7:1 column multiplexers (sel1..sel3). Code 0 picks linha[6] and code 6 picks linha[0]. Code 7 selects no input, so every row mux outputs 0; this code is the blanking code.
- Holds each column for a programmable dwell time and inserts a blanking gap between columns to suppress ghosting.
- Flags end-of-frame and advances a scroll offset used by the message ROM addressing.

Parameters:
- DWELL_CYCLES, 1000, clock cycles each column code is held (>=1).
- BLANK_CYCLES, 10, clock cycles of code 7 after each column (>=0; 0 disables blanking).
- FRAMES_PER_STEP, 30, completed frames per scroll step (>=1).
- MSG_LEN, 32, scroll wrap length (>=2); SP_W = clog2(MSG_LEN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  scan enable.
- scroll_en  in  1  allow scroll_pos to advance.
- sel  out  3  mux select code; sel[2]=sel1 (MSB), sel[1]=sel2, sel[0]=sel3.
- col_idx  out  3  column being shown, 0..6 (equals sel when not blanking, holds last column during blank).
- blank  out  1  1 while sel=7.
- frame_done  out  1  single-cycle pulse per completed 7-column frame.
- scroll_pos  out  SP_W  current scroll offset, 0..MSG_LEN-1.

Behaviour:
- All outputs registered. Reset applies on a clk edge with rst_n=0.
- Reset values: sel=7, col_idx=0, blank=1, frame_done=0, scroll_pos=0, state=IDLE, all counters 0.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - sel=7, blank=1.
  - en=1 sampled at edge k: from edge k, state=SHOW, sel=0, col_idx=0, blank=0.
- SHOW:
  - sel=col_idx for exactly DWELL_CYCLES cycles.
  - If BLANK_CYCLES>0: next state BLANK.
  - Else: the next column starts directly.
- BLANK:
  - sel=7, blank=1 for exactly BLANK_CYCLES cycles.
  - Then SHOW with col_idx+1.
- Column wrap: after column 6's dwell+blank, col_idx wraps to 0. No gap beyond the normal blank.
- Frame period = 7*(DWELL_CYCLES+BLANK_CYCLES) cycles.
- frame_done:
  - High for one cycle, during the last cycle of column 6's blank.
  - If BLANK_CYCLES=0, high during the last cycle of column 6's dwell.
- en deassert:
  - en=0 sampled at any edge in SHOW/BLANK → IDLE at that edge; sel=7, blank=1.
  - Dwell counter and col_idx reset to 0; no frame_done.
  - Re-enable always restarts at column 0.
- Scroll:
  - Frame counter increments on each frame_done while scroll_en=1.
  - When it reaches FRAMES_PER_STEP it clears and scroll_pos increments in that same cycle.
  - scroll_pos wraps MSG_LEN-1 → 0.
  - scroll_en=0 freezes the frame counter and scroll_pos; their values are retained.
  - en=0 does not clear scroll_pos.
- Reset mid-frame: everything returns to reset values on that edge, regardless of en.
- sel is never driven with a value that changes by more than one transition per cycle. sel never carries a value other than 0..7.

Decomposition:
- Package panel_pkg: SEL_BLANK=3'd7, NUM_COLS=7, scan state enum {IDLE, SHOW, BLANK}.
- One sub-module: panel_dwell_timer, a loadable down-counter with a done flag.
  - Instanced for the dwell/blank timing.
  - Its width derives from max(DWELL_CYCLES, BLANK_CYCLES).

Test Plan:
- Use DWELL=3, BLANK=1, FRAMES_PER_STEP=2, MSG_LEN=4 for all scenarios.
- Reset then en=1 → sel sequence 0,0,0,7,1,1,1,7,…,6,6,6,7,0; frame_done high only on the cycle of the final 7; period 28 cycles.
- scroll_en=1, run 8 frames → scroll_pos 0→1 (after frame 2) →2→3→0 (after frame 8), each change coincident with frame_done.
- en=0 while sel=4 → next edge sel=7, blank=1; en=1 again → sel=0 for 3 cycles; scroll_pos unchanged.
- rst_n=0 for one edge mid-frame (col 5, scroll_pos=2) → sel=7, col_idx=0, scroll_pos=0, frame_done=0.
- BLANK=0 rerun → sel 0,0,0,1,1,1,…,6,6,6,0; frame_done on last cycle of column 6; period 21 cycles.
- scroll_en=0 over 5 frames → scroll_pos constant; reassert → advances after 2 further frames (frame counter retained).
